// File: rtl/call_request_manager_if.sv
// Call-button bus between the panel/controller side and the call request manager.
interface call_request_manager_if;
  logic [3:0] btn;
  logic [1:0] current_floor;
  logic       door_open;
  logic [3:0] req;
  logic       req_any;
  logic [2:0] pending_count;

  // Controller/panel side drives buttons and car status, consumes pending calls.
  modport master (
    output btn,
    output current_floor,
    output door_open,
    input  req,
    input  req_any,
    input  pending_count
  );

  // Manager side.
  modport slave (
    input  btn,
    input  current_floor,
    input  door_open,
    output req,
    output req_any,
    output pending_count
  );
endinterface

// File: rtl/call_request_manager.sv
// Call request manager: synchronizes and debounces four floor-call buttons, latches
// debounced presses as pending calls and clears a call when the door opens at that floor.
module call_request_manager #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  call_request_manager_if.slave bus
);

  localparam logic [3:0] CntMax = 4'(DEBOUNCE_CYCLES - 1);

  logic [3:0] sync1_q, sync2_q;
  logic [3:0] stable_q, stable_d;
  logic [3:0] cnt_q [4];
  logic [3:0] cnt_d [4];
  logic [3:0] press;
  logic [3:0] clear;
  logic [3:0] req_q, req_d;
  logic       req_any_q, req_any_d;
  logic [2:0] count_q, count_d;

  // Per-floor debounce: count consecutive disagreeing samples, accept at CntMax.
  always_comb begin
    stable_d = stable_q;
    press    = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] >= CntMax) begin
          stable_d[i] = sync2_q[i];
          // Only debounced rising levels are call events; releases are silent.
          press[i]    = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Pending-call update; service clear overrides a same-edge press on that floor.
  always_comb begin
    clear     = bus.door_open ? (4'b0001 << bus.current_floor) : 4'b0000;
    req_d     = (req_q | press) & ~clear;
    req_any_d = |req_d;
    count_d   = '0;
    for (int i = 0; i < 4; i++) begin
      count_d = count_d + {2'b00, req_d[i]};
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      req_q     <= '0;
      req_any_q <= 1'b0;
      count_q   <= '0;
    end else begin
      sync1_q   <= bus.btn;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      req_q     <= req_d;
      req_any_q <= req_any_d;
      count_q   <= count_d;
    end
  end

  assign bus.req           = req_q;
  assign bus.req_any       = req_any_q;
  assign bus.pending_count = count_q;

endmodule

// File: tb/tb_call_request_manager.sv
// Self-checking bench for call_request_manager: table of stimulus rows with expected
// pending-call vectors, scoreboard queue, plus a hand-written async reset sequence.
module tb_call_request_manager;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  call_request_manager_if bus ();

  call_request_manager #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0] btn;
    logic       door;
    logic [1:0] floor;
    int         reps;
    logic [3:0] exp_req;
    string      name;
  } vec_t;

  typedef struct {
    logic [3:0] req;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic [3:0] b, input logic d, input logic [1:0] f, input int r,
                     input logic [3:0] e, input string nm);
    vec_t v;
    v.btn = b; v.door = d; v.floor = f; v.reps = r; v.exp_req = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input logic [3:0] e, input string nm);
    exp_t x;
    x.req  = e;
    x.name = nm;
    sb.push_back(x);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [2:0] ecnt;
    logic       eany;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: DUT output req=%b with no expectation queued", bus.req);
      return;
    end
    e    = sb.pop_front();
    ecnt = 3'($countones(e.req));
    eany = (e.req != 4'b0000);
    if (bus.req !== e.req || bus.req_any !== eany || bus.pending_count !== ecnt) begin
      n_fail++;
      $display("FAIL %s @%0t: got req=%b any=%b cnt=%0d, expected req=%b any=%b cnt=%0d",
               e.name, $time, bus.req, bus.req_any, bus.pending_count, e.req, eany, ecnt);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input logic [3:0] b, input logic d, input logic [1:0] f,
                      input logic [3:0] e, input string nm);
    bus.btn           = b;
    bus.door_open     = d;
    bus.current_floor = f;
    push_exp(e, nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    bus.btn           = 4'b0000;
    bus.door_open     = 1'b0;
    bus.current_floor = 2'd0;
    rst_n             = 1'b0;

    // Single press on floor 2, latency k+5, release, ignored floors, clear.
    add(4'b0100, 0, 0, 5, 4'b0000, "f2_press_latency");
    add(4'b0100, 0, 0, 1, 4'b0100, "f2_press_accept");
    add(4'b0000, 0, 0, 6, 4'b0100, "f2_release_no_event");
    add(4'b0000, 1, 1, 1, 4'b0100, "door_other_floor");
    add(4'b0000, 0, 2, 1, 4'b0100, "floor_ignored_door_closed");
    add(4'b0000, 1, 2, 1, 4'b0000, "f2_service_clear");
    // Two floors, partial clear, held buttons do not re-register.
    add(4'b1100, 0, 0, 5, 4'b0000, "f23_press_wait");
    add(4'b1100, 0, 0, 1, 4'b1100, "f23_press_accept");
    add(4'b1100, 1, 2, 1, 4'b1000, "f2_clear_of_1100");
    add(4'b1100, 0, 0, 3, 4'b1000, "held_no_reregister");
    add(4'b0000, 1, 3, 1, 4'b0000, "f3_clear");
    add(4'b0000, 0, 0, 6, 4'b0000, "f23_release");
    // All four simultaneously, then clears.
    add(4'b1111, 0, 0, 5, 4'b0000, "all_press_wait");
    add(4'b1111, 0, 0, 1, 4'b1111, "all_press_accept");
    add(4'b1111, 1, 0, 1, 4'b1110, "all_clear_f0");
    add(4'b0000, 0, 0, 6, 4'b1110, "all_release");
    add(4'b0000, 1, 1, 1, 4'b1100, "clear_f1");
    add(4'b0000, 1, 2, 1, 4'b1000, "clear_f2");
    add(4'b0000, 1, 3, 1, 4'b0000, "clear_f3");
    // Bounces shorter than the debounce window produce nothing; 4 cycles just accepts.
    add(4'b1000, 0, 0, 2, 4'b0000, "bounce2_high");
    add(4'b0000, 0, 0, 8, 4'b0000, "bounce2_low");
    add(4'b1000, 0, 0, 3, 4'b0000, "bounce3_high");
    add(4'b0000, 0, 0, 8, 4'b0000, "bounce3_low");
    add(4'b1000, 0, 0, 4, 4'b0000, "pulse4_high");
    add(4'b0000, 0, 0, 1, 4'b0000, "pulse4_wait");
    add(4'b0000, 0, 0, 1, 4'b1000, "pulse4_accept");
    add(4'b0000, 0, 0, 6, 4'b1000, "pulse4_hold");
    add(4'b0000, 1, 3, 1, 4'b0000, "pulse4_clear");
    // Press accepted on the same edge as service clear: clear wins, held stays clear.
    add(4'b0010, 0, 0, 5, 4'b0000, "f1_press_wait");
    add(4'b0010, 1, 1, 1, 4'b0000, "f1_accept_vs_clear");
    add(4'b0010, 0, 0, 6, 4'b0000, "f1_held_stays_clear");
    add(4'b0000, 0, 0, 6, 4'b0000, "f1_release");
    add(4'b0010, 0, 0, 5, 4'b0000, "f1_repress_wait");
    add(4'b0010, 0, 0, 1, 4'b0010, "f1_repress_accept");
    add(4'b0000, 1, 1, 1, 4'b0000, "f1_repress_clear");
    add(4'b0000, 0, 0, 6, 4'b0000, "f1_repress_release");

    repeat (2) @(posedge clk);
    #1;
    push_exp(4'b0000, "reset_state");
    check_out();
    #2 rst_n = 1'b1;

    foreach (vecs[v]) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        step(vecs[v].btn, vecs[v].door, vecs[v].floor, vecs[v].exp_req, vecs[v].name);
      end
    end

    // Async reset with pending calls and floor 3 mid-debounce.
    for (int r = 0; r < 5; r++) step(4'b0110, 0, 0, 4'b0000, "pre_reset_wait");
    step(4'b0110, 0, 0, 4'b0110, "pre_reset_load");
    for (int r = 0; r < 3; r++) step(4'b1000, 0, 0, 4'b0110, "f3_mid_debounce");
    #1 rst_n = 1'b0;
    #1;
    push_exp(4'b0000, "async_reset_immediate");
    check_out();
    #1 rst_n = 1'b1;
    for (int r = 0; r < 5; r++) step(4'b1000, 0, 0, 4'b0000, "post_reset_wait");
    step(4'b1000, 0, 0, 4'b1000, "post_reset_press");
    step(4'b1000, 1, 3, 4'b0000, "post_reset_clear");

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d expectations never compared, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/call_request_manager.md
CALL_REQUEST_MANAGER -- requirements
Module: call_request_manager

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4 (legal 2..15): consecutive cycles a synchronized button level must differ from its debounced level before the change is accepted.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 btn  input  4  raw, asynchronous, bouncing call buttons; bit i = call to floor i.
REQ-005 current_floor  input  2  floor currently occupied by the car, from the elevator controller.
REQ-006 door_open  input  1  high while the controller holds the door open at current_floor.
REQ-007 req  output  4  registered pending-call vector; bit i = call to floor i outstanding; drives the controller's req input.
REQ-008 req_any  output  1  registered; high iff req != 0.
REQ-009 pending_count  output  3  registered population count of req (0..4).

Function
REQ-010 Each btn[i] SHALL pass through a two-flop synchronizer (sync1 -> sync2) before any other use.
REQ-011 Per floor, the block SHALL hold a debounced level stable[i] and a 4-bit counter cnt[i].
REQ-012 Per edge: sync2[i] == stable[i] -> cnt[i] <= 0.
REQ-013 Per edge: sync2[i] != stable[i] and cnt[i] < DEBOUNCE_CYCLES-1 -> cnt[i] <= cnt[i]+1.
REQ-014 Per edge: sync2[i] != stable[i] and cnt[i] == DEBOUNCE_CYCLES-1 -> stable[i] <= sync2[i], cnt[i] <= 0 (accept).
REQ-015 A press event for floor i SHALL be an accept edge where sync2[i] = 1 (debounced 0->1 only); releases generate no event.
REQ-016 Press event latency: btn[i] held high from before edge k SHALL set req[i], visible after edge k+1+DEBOUNCE_CYCLES (edge k+5 for default).
REQ-017 A bounce (sync2 returning to stable) before acceptance SHALL reset cnt[i] to 0 and produce no event.
REQ-018 Service clear: an edge sampling door_open = 1 with current_floor = i SHALL clear req[i] on that edge.
REQ-019 Press event and service clear for the same floor on the same edge: clear wins, req[i] = 0.
REQ-020 Press event for floor i while req[i] is already 1: no change (calls not counted twice).
REQ-021 A button held continuously SHALL generate exactly one event; re-registration requires a debounced release then a new press.
REQ-022 Floors SHALL be independent: simultaneous events/clears on different floors all take effect on the same edge.
REQ-023 req_any and pending_count SHALL be updated on the same edge as req, consistent with the new req value (no extra cycle of lag).
REQ-024 current_floor is sampled only when door_open = 1; other values are ignored.

Reset
REQ-025 rst_n low SHALL immediately force sync1, sync2, stable, cnt, req to 0, req_any = 0, pending_count = 0.
REQ-026 Reset asserted mid-debounce or with pending calls SHALL discard all progress and pending calls.
REQ-027 After rst_n release, a button still held SHALL register as a new press (stable restarts at 0) with REQ-016 latency.

Verification
REQ-028 Default params, btn = 4'b0100 held from before edge k, door_open = 0 -> req = 4'b0100, req_any = 1, pending_count = 1 after edge k+5; req = 0 before that.
REQ-029 btn[3] pulses high for 2 cycles, then low -> req stays 4'b0000; cnt[3] returns to 0.
REQ-030 req = 4'b1100, edge with door_open = 1, current_floor = 2 -> next req = 4'b1000, pending_count = 1.
REQ-031 Press event on floor 1 accepted on the same edge as door_open = 1, current_floor = 1 -> req[1] = 0; button held thereafter -> req[1] stays 0 until release and re-press.
REQ-032 btn = 4'b1111 simultaneously -> req = 4'b1111, pending_count = 4 on one edge; then door_open with current_floor = 0 -> req = 4'b1110, pending_count = 3.
REQ-033 req = 4'b0110 and cnt mid-count on floor 3, rst_n pulsed low between edges -> outputs 0 immediately without waiting for clk; btn[3] still held -> req[3] set 1+DEBOUNCE_CYCLES edges after the first post-release edge.
